// File: rtl/divider_asm_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and default word width.
package divider_asm_pkg;

  localparam int L_WORD_DEFAULT = 4;

  typedef enum logic {
    S_idle    = 1'b0,
    S_running = 1'b1
  } state_t;

endpackage

// File: rtl/divider_asm_step.sv
// One combinational restoring-division step: compare the shifted partial remainder
// with the divisor, conditionally subtract, and produce the quotient bit.
module divider_asm_step #(
  parameter int L_word = 4
) (
  input  logic [L_word:0]   rem_in,
  input  logic [L_word-1:0] divisor,
  output logic [L_word-1:0] rem_out,
  output logic              q_bit
);

  always_comb begin
    q_bit = (rem_in >= {1'b0, divisor});
    // The restored result is always below divisor, so L_word-bit modular arithmetic is exact.
    if (q_bit) rem_out = rem_in[L_word-1:0] - divisor;
    else       rem_out = rem_in[L_word-1:0];
  end

endmodule

// File: rtl/divider_asm.sv
// Unsigned 2*L_word / L_word restoring divider, one quotient bit per clock,
// with divide-by-zero/overflow detection and a zero-dividend fast path.
module divider_asm
  import divider_asm_pkg::*;
#(
  parameter int L_word = L_WORD_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2*L_word-1:0]   dividend,
  input  logic [L_word-1:0]     divisor,
  input  logic                  Start,
  output logic [L_word-1:0]     quotient,
  output logic [L_word-1:0]     remainder,
  output logic                  Ready,
  output logic                  Error
);

  localparam int CNT_W = $clog2(L_word + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(L_word);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [L_word-1:0] rem_q, rem_d;
  logic [L_word-1:0] quot_q, quot_d;
  logic [L_word-1:0] dvd_lo_q, dvd_lo_d;
  logic [L_word-1:0] dvs_q, dvs_d;
  logic              err_q, err_d;

  logic [L_word-1:0] step_rem;
  logic              step_q_bit;

  divider_asm_step #(.L_word(L_word)) u_step (
    .rem_in  ({rem_q, dvd_lo_q[L_word-1]}),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q_bit)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvd_lo_d = dvd_lo_q;
    dvs_d    = dvs_q;
    err_d    = err_q;
    unique case (state_q)
      S_idle: begin
        if (Start) begin
          // Overflow: the upper half must be below the divisor for the quotient to fit.
          if (divisor == '0 || dividend[2*L_word-1:L_word] >= divisor) begin
            err_d  = 1'b1;
            quot_d = '0;
            rem_d  = '0;
          end else if (dividend == '0) begin
            err_d  = 1'b0;
            quot_d = '0;
            rem_d  = '0;
          end else begin
            err_d    = 1'b0;
            rem_d    = dividend[2*L_word-1:L_word];
            dvd_lo_d = dividend[L_word-1:0];
            dvs_d    = divisor;
            quot_d   = '0;
            cnt_d    = CNT_LOAD;
            state_d  = S_running;
          end
        end
      end
      S_running: begin
        rem_d    = step_rem;
        quot_d   = {quot_q[L_word-2:0], step_q_bit};
        dvd_lo_d = {dvd_lo_q[L_word-2:0], 1'b0};
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_idle;
      end
      default: state_d = S_idle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_idle;
      cnt_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvd_lo_q <= '0;
      dvs_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvd_lo_q <= dvd_lo_d;
      dvs_q    <= dvs_d;
      err_q    <= err_d;
    end
  end

  assign Ready     = (state_q == S_idle) && !reset;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign Error     = err_q;

endmodule
